// File: rtl/level_sequencer_mux.sv
`default_nettype none
// ============================================================================
// Module      : level_sequencer_mux
// Description : Game level sequencer driving a registered, blanked selection
//               of per-level pattern data to the lane/obstacle generators.
// Revision    : 1.0 - initial release
// ============================================================================
module level_sequencer_mux #(
    parameter int NUM_LEVELS  = 4,
    parameter int DATAWIDTH   = 8,
    parameter int SELWIDTH    = 2,
    parameter int WRAP_MODE   = 0,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                            CC_LEVELSEQ_CLOCK_50,
    input  logic                            CC_LEVELSEQ_RESET_InLow,
    input  logic [NUM_LEVELS*DATAWIDTH-1:0] CC_LEVELSEQ_data_InBUS,
    input  logic                            CC_LEVELSEQ_levelUp_In,
    input  logic                            CC_LEVELSEQ_restart_In,
    output logic [SELWIDTH-1:0]             CC_LEVELSEQ_select_Out,
    output logic [DATAWIDTH-1:0]            CC_LEVELSEQ_z_Out,
    output logic                            CC_LEVELSEQ_valid_Out,
    output logic                            CC_LEVELSEQ_last_Out,
    output logic                            CC_LEVELSEQ_done_Out
);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]          HOLD_INIT = 8'(HOLD_CYCLES - 1);
    localparam logic [SELWIDTH-1:0] LAST_SEL  = SELWIDTH'(NUM_LEVELS - 1);

    state_t               state;
    logic [7:0]           hold_cnt;
    logic                 level_up_q;
    logic                 up_evt;
    logic                 at_last;
    logic [DATAWIDTH-1:0] cur_data;

    assign up_evt               = CC_LEVELSEQ_levelUp_In & ~level_up_q;
    assign at_last              = (CC_LEVELSEQ_select_Out == LAST_SEL);
    assign CC_LEVELSEQ_last_Out = at_last;

    // Any select value outside the populated channels falls back to level 0.
    always_comb begin
        cur_data = CC_LEVELSEQ_data_InBUS[DATAWIDTH-1:0];
        for (int k = 1; k < NUM_LEVELS; k++) begin
            if (CC_LEVELSEQ_select_Out == SELWIDTH'(k)) begin
                cur_data = CC_LEVELSEQ_data_InBUS[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge CC_LEVELSEQ_CLOCK_50 or negedge CC_LEVELSEQ_RESET_InLow) begin
        if (!CC_LEVELSEQ_RESET_InLow) begin
            state                  <= S_HOLD;
            hold_cnt               <= HOLD_INIT;
            level_up_q             <= 1'b0;
            CC_LEVELSEQ_select_Out <= '0;
            CC_LEVELSEQ_z_Out      <= '0;
            CC_LEVELSEQ_valid_Out  <= 1'b0;
            CC_LEVELSEQ_done_Out   <= 1'b0;
        end else begin
            level_up_q <= CC_LEVELSEQ_levelUp_In;
            if (CC_LEVELSEQ_restart_In) begin
                state                  <= S_HOLD;
                hold_cnt               <= HOLD_INIT;
                CC_LEVELSEQ_select_Out <= '0;
                CC_LEVELSEQ_z_Out      <= '0;
                CC_LEVELSEQ_valid_Out  <= 1'b0;
                CC_LEVELSEQ_done_Out   <= 1'b0;
            end else begin
                case (state)
                    S_HOLD: begin
                        CC_LEVELSEQ_z_Out     <= '0;
                        CC_LEVELSEQ_valid_Out <= 1'b0;
                        if (hold_cnt == 8'd0) begin
                            state <= S_PLAY;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    S_PLAY: begin
                        if (up_evt) begin
                            CC_LEVELSEQ_z_Out     <= '0;
                            CC_LEVELSEQ_valid_Out <= 1'b0;
                            hold_cnt              <= HOLD_INIT;
                            if (!at_last) begin
                                CC_LEVELSEQ_select_Out <= CC_LEVELSEQ_select_Out + SELWIDTH'(1);
                                state                  <= S_HOLD;
                            end else if (WRAP_MODE != 0) begin
                                CC_LEVELSEQ_select_Out <= '0;
                                state                  <= S_HOLD;
                            end else begin
                                CC_LEVELSEQ_done_Out <= 1'b1;
                                state                <= S_DONE;
                            end
                        end else begin
                            CC_LEVELSEQ_z_Out     <= cur_data;
                            CC_LEVELSEQ_valid_Out <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        CC_LEVELSEQ_z_Out     <= '0;
                        CC_LEVELSEQ_valid_Out <= 1'b0;
                        CC_LEVELSEQ_done_Out  <= 1'b1;
                    end
                    default: begin
                        state    <= S_HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_level_sequencer_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_sequencer_mux
// Description : Bench for level_sequencer_mux; saturating and wrapping copies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_sequencer_mux;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] data;
    logic            level_up;
    logic            restart;
    logic [SW-1:0]   sel_s, sel_w;
    logic [DW-1:0]   z_s, z_w;
    logic            valid_s, valid_w, last_s, last_w, done_s, done_w;

    int errors = 0;
    int checks = 0;

    // Reference model: timestamps of when each copy enters play.
    int            n = 0;
    int            lvl[2];
    int            pf[2];
    bit            dn[2];
    bit            prev_up;
    logic [SW-1:0] e_sel[2];
    logic [DW-1:0] e_z[2];
    logic          e_valid[2], e_last[2], e_done[2];

    always #5 clk = ~clk;

    level_sequencer_mux #(.NUM_LEVELS(N), .DATAWIDTH(DW), .SELWIDTH(SW),
                          .WRAP_MODE(0), .HOLD_CYCLES(H)) dut_sat (
        .CC_LEVELSEQ_CLOCK_50(clk), .CC_LEVELSEQ_RESET_InLow(rst_n),
        .CC_LEVELSEQ_data_InBUS(data), .CC_LEVELSEQ_levelUp_In(level_up),
        .CC_LEVELSEQ_restart_In(restart), .CC_LEVELSEQ_select_Out(sel_s),
        .CC_LEVELSEQ_z_Out(z_s), .CC_LEVELSEQ_valid_Out(valid_s),
        .CC_LEVELSEQ_last_Out(last_s), .CC_LEVELSEQ_done_Out(done_s));

    level_sequencer_mux #(.NUM_LEVELS(N), .DATAWIDTH(DW), .SELWIDTH(SW),
                          .WRAP_MODE(1), .HOLD_CYCLES(H)) dut_wrap (
        .CC_LEVELSEQ_CLOCK_50(clk), .CC_LEVELSEQ_RESET_InLow(rst_n),
        .CC_LEVELSEQ_data_InBUS(data), .CC_LEVELSEQ_levelUp_In(level_up),
        .CC_LEVELSEQ_restart_In(restart), .CC_LEVELSEQ_select_Out(sel_w),
        .CC_LEVELSEQ_z_Out(z_w), .CC_LEVELSEQ_valid_Out(valid_w),
        .CC_LEVELSEQ_last_Out(last_w), .CC_LEVELSEQ_done_Out(done_w));

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            lvl[w] = 0;
            dn[w]  = 1'b0;
            pf[w]  = n + H;
        end
        prev_up = 1'b0;
    endtask

    task automatic step();
        bit evt, was_play, acc;
        @(posedge clk);
        n++;
        evt = level_up && !prev_up;
        for (int w = 0; w < 2; w++) begin
            was_play = !dn[w] && (n - 1 >= pf[w]);
            acc      = 1'b0;
            if (restart) begin
                lvl[w] = 0;
                dn[w]  = 1'b0;
                pf[w]  = n + H;
            end else if (evt && was_play) begin
                acc = 1'b1;
                if (lvl[w] < N - 1) begin
                    lvl[w]++;
                    pf[w] = n + H;
                end else if (w == 1) begin
                    lvl[w] = 0;
                    pf[w]  = n + H;
                end else begin
                    dn[w] = 1'b1;
                end
            end
            e_valid[w] = was_play && !restart && !acc;
            e_z[w]     = e_valid[w] ? data[lvl[w]*DW +: DW] : '0;
            e_sel[w]   = SW'(lvl[w]);
            e_last[w]  = (lvl[w] == N - 1);
            e_done[w]  = dn[w];
        end
        prev_up = level_up;
        #1;
    endtask

    task automatic wait_valid(input int w, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 99;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            if ((w == 0 ? valid_s : valid_w) === 1'b1) begin
                edges = i;
                seen  = 1'b1;
            end
        end
    endtask

    task automatic pulse_up();
        level_up = 1'b1;
        step();
        level_up = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({sel_s, z_s, valid_s, last_s, done_s} !== '0) begin
            errors++;
            $display("FAIL reset_sat: got %h want 0", {sel_s, z_s, valid_s, last_s, done_s});
        end
        checks++;
        if ({sel_w, z_w, valid_w, last_w, done_w} !== '0) begin
            errors++;
            $display("FAIL reset_wrap: got %h want 0", {sel_w, z_w, valid_w, last_w, done_w});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_valid();
        for (int i = 1; i <= H; i++) begin
            step();
            checks++;
            if ({valid_s, valid_w} !== 2'b00) begin
                errors++;
                $display("FAIL early_valid edge %0d: got %b want 00", i, {valid_s, valid_w});
            end
        end
        step();
        checks++;
        if ({valid_s, z_s, sel_s, last_s} !== {1'b1, 8'h11, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL first_valid_sat: got %h want %h", {valid_s, z_s, sel_s, last_s}, {1'b1, 8'h11, 2'd0, 1'b0});
        end
        checks++;
        if ({valid_w, z_w, sel_w, last_w} !== {1'b1, 8'h11, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL first_valid_wrap: got %h want %h", {valid_w, z_w, sel_w, last_w}, {1'b1, 8'h11, 2'd0, 1'b0});
        end
    endtask

    task automatic test_level_up_pulse();
        int e;
        pulse_up();
        checks++;
        if ({valid_s, z_s, valid_w, z_w} !== '0) begin
            errors++;
            $display("FAIL blank_after_up: got %h want 0", {valid_s, z_s, valid_w, z_w});
        end
        wait_valid(0, e);
        checks++;
        if (e !== H + 1) begin
            errors++;
            $display("FAIL up_latency: got %0d edges want %0d", e, H + 1);
        end
        checks++;
        if ({sel_s, z_s, valid_w, sel_w, z_w} !== {2'd1, 8'h22, 1'b1, 2'd1, 8'h22}) begin
            errors++;
            $display("FAIL level1_data: got %h want %h", {sel_s, z_s, valid_w, sel_w, z_w}, {2'd1, 8'h22, 1'b1, 2'd1, 8'h22});
        end
    endtask

    task automatic test_level_held();
        int e;
        restart = 1'b1;
        step();
        restart = 1'b0;
        wait_valid(0, e);
        checks++;
        if (e !== H + 1) begin
            errors++;
            $display("FAIL restart_latency: got %0d edges want %0d", e, H + 1);
        end
        level_up = 1'b1;
        repeat (20) step();
        level_up = 1'b0;
        checks++;
        if ({sel_s, valid_s, sel_w, valid_w} !== {2'd1, 1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL held_level_up: got %h want %h", {sel_s, valid_s, sel_w, valid_w}, {2'd1, 1'b1, 2'd1, 1'b1});
        end
        step();
        pulse_up();
        step();
        level_up = 1'b1;
        step();
        level_up = 1'b0;
        wait_valid(0, e);
        checks++;
        if (e !== 3 || sel_s !== 2'd2 || sel_w !== 2'd2) begin
            errors++;
            $display("FAIL hold_ignores_up: got edges=%0d sel=%0d/%0d want edges=3 sel=2/2", e, sel_s, sel_w);
        end
    endtask

    task automatic test_last_level();
        int e;
        pulse_up();
        wait_valid(0, e);
        checks++;
        if ({sel_s, last_s, last_w} !== {2'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL last_flag: got %h want %h", {sel_s, last_s, last_w}, {2'd3, 1'b1, 1'b1});
        end
        pulse_up();
        checks++;
        if ({done_s, valid_s, z_s, sel_s} !== {1'b1, 1'b0, 8'h00, 2'd3}) begin
            errors++;
            $display("FAIL enter_done: got %h want %h", {done_s, valid_s, z_s, sel_s}, {1'b1, 1'b0, 8'h00, 2'd3});
        end
        checks++;
        if ({done_w, valid_w, sel_w} !== {1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL wrap_step: got %h want %h", {done_w, valid_w, sel_w}, {1'b0, 1'b0, 2'd0});
        end
        step();
        pulse_up();
        step();
        checks++;
        if ({done_s, valid_s, sel_s} !== {1'b1, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL done_sticky: got %h want %h", {done_s, valid_s, sel_s}, {1'b1, 1'b0, 2'd3});
        end
        wait_valid(1, e);
        checks++;
        if (e !== 2 || {sel_w, z_w, done_w} !== {2'd0, 8'h11, 1'b0}) begin
            errors++;
            $display("FAIL wrap_to_zero: got edges=%0d %h want edges=2 %h", e, {sel_w, z_w, done_w}, {2'd0, 8'h11, 1'b0});
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({done_s, sel_s, valid_s} !== 4'b0000) begin
            errors++;
            $display("FAIL restart_from_done: got %b want 0000", {done_s, sel_s, valid_s});
        end
        wait_valid(0, e);
        checks++;
        if (e !== H + 1 || z_s !== 8'h11) begin
            errors++;
            $display("FAIL done_restart_latency: got edges=%0d z=%h want edges=%0d z=11", e, z_s, H + 1);
        end
    endtask

    task automatic test_restart_priority();
        int e;
        pulse_up();
        wait_valid(0, e);
        pulse_up();
        wait_valid(0, e);
        restart  = 1'b1;
        level_up = 1'b1;
        step();
        restart  = 1'b0;
        level_up = 1'b0;
        checks++;
        if ({sel_s, valid_s, done_s, sel_w, valid_w} !== '0) begin
            errors++;
            $display("FAIL restart_priority: got %h want 0", {sel_s, valid_s, done_s, sel_w, valid_w});
        end
    endtask

    task automatic test_async_reset();
        int e;
        wait_valid(0, e);
        pulse_up();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({sel_s, z_s, valid_s, last_s, done_s, sel_w, z_w, valid_w} !== '0) begin
            errors++;
            $display("FAIL async_reset_hold: got %h want 0", {sel_s, z_s, valid_s, last_s, done_s, sel_w, z_w, valid_w});
        end
        rst_n = 1'b1;
        wait_valid(0, e);
        checks++;
        if (e !== H + 1) begin
            errors++;
            $display("FAIL reset_latency: got %0d edges want %0d", e, H + 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({z_s, valid_s, z_w, valid_w} !== '0) begin
            errors++;
            $display("FAIL async_reset_play: got %h want 0", {z_s, valid_s, z_w, valid_w});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) data = $urandom;
            level_up = ($urandom_range(0, 3) == 0);
            restart  = ($urandom_range(0, 59) == 0);
            step();
            checks++;
            if ({sel_s, z_s, valid_s, last_s, done_s} !== {e_sel[0], e_z[0], e_valid[0], e_last[0], e_done[0]}) begin
                errors++;
                $display("FAIL random_sat cycle %0d: got %h want %h", i, {sel_s, z_s, valid_s, last_s, done_s},
                         {e_sel[0], e_z[0], e_valid[0], e_last[0], e_done[0]});
            end
            checks++;
            if ({sel_w, z_w, valid_w, last_w, done_w} !== {e_sel[1], e_z[1], e_valid[1], e_last[1], e_done[1]}) begin
                errors++;
                $display("FAIL random_wrap cycle %0d: got %h want %h", i, {sel_w, z_w, valid_w, last_w, done_w},
                         {e_sel[1], e_z[1], e_valid[1], e_last[1], e_done[1]});
            end
        end
        level_up = 1'b0;
        restart  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        data     = 32'h44332211;
        level_up = 1'b0;
        restart  = 1'b0;
        #3;
        test_reset();
        test_first_valid();
        test_level_up_pulse();
        test_level_held();
        test_last_level();
        test_restart_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
